// File: rtl/mem_arbiter_v1_pkg.sv
// mem_arb_pkg_v1: shared types and constants for the two-port memory arbiter.
//   arb_state_t   - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   ERR_*         - bit positions inside arb_error_vector
//   PORT_*        - requester indices (0 = instruction fetch, 1 = load/store)
package mem_arb_pkg_v1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam int ERR_W        = 8;
   localparam int ERR_REQ_DROP = 0;
   localparam int ERR_MISALIGN = 1;

   localparam int PORT_FETCH = 0;
   localparam int PORT_DATA  = 1;

   // Latency down-counter width; covers MEM_LATENCY 1..4.
   localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_v1_if.sv
// mem_arbiter_v1_if: bundle of both requester ports, the memory_v1 port and the
// arbiter status outputs.
//   slave  - seen by the arbiter: takes requests and mem_data_out, drives acks,
//            read data, the memory strobe/address/data and status.
//   master - seen by the environment (requesters + memory): the reverse.
interface mem_arbiter_v1_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Port 0: instruction fetch
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;

   // Port 1: load/store
   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;

   // memory_v1 side
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_we;
   logic [DATA_W-1:0] mem_data_out;

   // Status
   logic              arb_busy;
   logic [7:0]        arb_error_vector;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_data_out,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output mem_addr, mem_data_in, mem_we,
      output arb_busy, arb_error_vector
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_data_out,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  mem_addr, mem_data_in, mem_we,
      input  arb_busy, arb_error_vector
   );

endinterface

// File: rtl/mem_arbiter_v1_rr_pick2.sv
// rr_pick2_v1: combinational two-way round-robin picker.
//   req[1:0]    - pending requests, bit index = port
//   last_grant  - port index that won the previous arbitration
//   grant[1:0]  - one-hot winner (all zero when nothing is pending)
//   any_grant   - at least one request is pending
module rr_pick2_v1 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant,
   output logic       any_grant
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // Tie: the port that did not win last time goes first.
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
      any_grant = |req;
   end

endmodule

// File: rtl/mem_arbiter_v1.sv
// mem_arbiter_v1: shares the single memory_v1 port between the instruction-fetch
// requester (port 0) and the load/store requester (port 1).
//   clk   - system clock, rising edge
//   rst   - asynchronous, active-high reset
//   bus   - mem_arbiter_v1_if.slave: level-held req/we/addr/wdata per port,
//           one-cycle ack + held rdata per port, registered memory address/data,
//           single-cycle write strobe, arb_busy and sticky arb_error_vector.
// One transaction at a time: IDLE (arbitrate) -> ISSUE -> [WAIT x MEM_LATENCY
// for reads] -> RESP (ack) -> IDLE. MEM_LATENCY must be in 1..4.
module mem_arbiter_v1
   import mem_arb_pkg_v1::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input logic              clk,
   input logic              rst,
   mem_arbiter_v1_if.slave  bus
);

   arb_state_t        state_q, state_d;
   logic              last_grant_q;
   logic              cur_port_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic [1:0]        err_q;

   logic [1:0]        req_vec;
   logic [1:0]        grant;
   logic              any_grant;
   logic              win_port;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              win_we;
   logic              cur_req;

   assign req_vec[PORT_FETCH] = bus.m0_req;
   assign req_vec[PORT_DATA]  = bus.m1_req;

   rr_pick2_v1 u_pick (
      .req        (req_vec),
      .last_grant (last_grant_q),
      .grant      (grant),
      .any_grant  (any_grant)
   );

   assign win_port  = (grant == 2'b10);
   assign win_addr  = win_port ? bus.m1_addr  : bus.m0_addr;
   assign win_wdata = win_port ? bus.m1_wdata : bus.m0_wdata;
   assign win_we    = win_port ? bus.m1_we    : bus.m0_we;
   // Request line of the port currently being served, for early-drop detection.
   assign cur_req   = cur_port_q ? bus.m1_req : bus.m0_req;

   // Next-state and decoded outputs.
   always_comb begin
      state_d      = state_q;
      bus.mem_we   = 1'b0;
      bus.m0_ack   = 1'b0;
      bus.m1_ack   = 1'b0;
      bus.arb_busy = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE: begin
            if (any_grant) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            // The strobe exists only here, so a write is issued exactly once.
            bus.mem_we = we_q;
            state_d    = we_q ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            bus.m0_ack = ~cur_port_q;
            bus.m1_ack = cur_port_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b0;
         cur_port_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         err_q        <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            ST_IDLE: begin
               if (any_grant) begin
                  last_grant_q <= win_port;
                  cur_port_q   <= win_port;
                  // Word-aligned issue: the low byte-offset bits are dropped.
                  addr_q       <= {win_addr[ADDR_W-1:2], 2'b00};
                  wdata_q      <= win_wdata;
                  we_q         <= win_we;
                  if (win_addr[1:0] != 2'b00) err_q[ERR_MISALIGN] <= 1'b1;
               end
            end
            ST_ISSUE: begin
               cnt_q <= CNT_W'(MEM_LATENCY);
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               // Read data is valid during the last WAIT cycle.
               if (cnt_q == CNT_W'(1)) begin
                  if (cur_port_q) rdata1_q <= bus.mem_data_out;
                  else            rdata0_q <= bus.mem_data_out;
               end
            end
            default: ;
         endcase
         // Dropping req before the ack cycle is a protocol violation; the
         // transaction itself is still completed.
         if ((state_q == ST_ISSUE || state_q == ST_WAIT) && !cur_req)
            err_q[ERR_REQ_DROP] <= 1'b1;
      end
   end

   assign bus.mem_addr         = addr_q;
   assign bus.mem_data_in      = wdata_q;
   assign bus.m0_rdata         = rdata0_q;
   assign bus.m1_rdata         = rdata1_q;
   assign bus.arb_error_vector = {{(ERR_W-2){1'b0}}, err_q};

endmodule

// File: tb/tb_mem_arbiter_v1.sv
// tb_mem_arbiter_v1: directed scenarios followed by a randomized phase for
// mem_arbiter_v1. A small memory stand-in answers on the memory port; expected
// values come from a transaction-level model (grant rule, latency arithmetic
// and a reference copy of memory contents).
module tb_mem_arbiter_v1;

   localparam int L      = 1;
   localparam int N_RAND = 300;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_v1_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter_v1 #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- memory stand-in (64 words, L-cycle read pipeline) -------
   logic [31:0] mem_arr [64];
   logic [31:0] pipe [L];

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEAD_BEEF;
      return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   initial begin : memory_model
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
      for (int i = 0; i < L; i++) pipe[i] <= '0;
      forever begin
         @(posedge clk);
         if (bus.mem_we) mem_arr[bus.mem_addr[7:2]] <= bus.mem_data_in;
         pipe[0] <= mem_arr[bus.mem_addr[7:2]];
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign bus.mem_data_out = pipe[L-1];

   // ---------------- bookkeeping and model state -----------------------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [64];
   logic [31:0] exp_rd [2];
   logic [31:0] exp_err;
   logic [31:0] cur_addr [2];
   int          m_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int p, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
      if (p == 0) begin
         bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
      end else begin
         bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_mem_we"},   32'(bus.mem_we), 32'd0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      check({tag, "_mem_din"},  bus.mem_data_in, 32'd0);
      check({tag, "_rdata0"},   bus.m0_rdata, 32'd0);
      check({tag, "_rdata1"},   bus.m1_rdata, 32'd0);
      check({tag, "_ack0"},     32'(bus.m0_ack), 32'd0);
      check({tag, "_ack1"},     32'(bus.m1_ack), 32'd0);
      check({tag, "_busy"},     32'(bus.arb_busy), 32'd0);
      check({tag, "_err"},      32'(bus.arb_error_vector), 32'd0);
   endtask

   // Random-phase requester/model state
   logic        pend [2];
   logic        r_we [2];
   logic [31:0] r_addr [2];
   logic [31:0] r_wdata [2];
   int          next_arb, exp_ack, grant_c, exp_port, winner, n, we_cnt;
   logic        exp_we, seen;
   logic [31:0] exp_val;

   initial begin
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_err   = '0;
      m_last    = 0;

      // ---- reset state ----
      #2;
      check_reset("por");
      tick();
      tick();
      rst = 1'b0;
      tick();

      // ---- port 0 reads 0x10 alone ----
      set_req(0, 1'b1, 1'b0, 32'h10, 32'd0);
      m_last = 0;
      for (int k = 1; k <= L + 2; k++) begin
         tick();
         check("rd0_ack0", 32'(bus.m0_ack), 32'(k == L + 2));
         check("rd0_ack1", 32'(bus.m1_ack), 32'd0);
         if (k == 1) begin
            check("rd0_mem_addr", bus.mem_addr, 32'h10);
            check("rd0_mem_we", 32'(bus.mem_we), 32'd0);
         end
      end
      exp_rd[0] = ref_mem[4];
      check("rd0_rdata", bus.m0_rdata, exp_rd[0]);
      set_req(0, 1'b0, 1'b0, 32'h10, 32'd0);
      tick();
      check("rd0_ack_width", 32'(bus.m0_ack), 32'd0);
      check("rd0_rdata_held", bus.m0_rdata, exp_rd[0]);

      // ---- port 1 writes 0x12345678 to 0x40 ----
      set_req(1, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
      m_last = 1;
      we_cnt = 0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (bus.mem_we) we_cnt++;
         if (k == 1) begin
            check("wr1_mem_addr", bus.mem_addr, 32'h40);
            check("wr1_mem_din", bus.mem_data_in, 32'h1234_5678);
         end
         check("wr1_ack1", 32'(bus.m1_ack), 32'(k == 2));
         check("wr1_ack0", 32'(bus.m0_ack), 32'd0);
         if (k == 2) begin
            check("wr1_rdata_unchanged", bus.m1_rdata, exp_rd[1]);
            set_req(1, 1'b0, 1'b1, 32'h40, 32'h1234_5678);
         end
      end
      check("wr1_we_cycles", 32'(we_cnt), 32'd1);
      ref_mem[16] = 32'h1234_5678;

      // ---- port 0 misaligned read of 0x13 ----
      set_req(0, 1'b1, 1'b0, 32'h13, 32'd0);
      m_last = 0;
      exp_err = exp_err | 32'h2;
      for (int k = 1; k <= L + 2; k++) begin
         tick();
         if (k == 1) check("mis_mem_addr", bus.mem_addr, 32'h10);
         check("mis_ack0", 32'(bus.m0_ack), 32'(k == L + 2));
      end
      exp_rd[0] = ref_mem[4];
      check("mis_rdata", bus.m0_rdata, exp_rd[0]);
      check("mis_err", 32'(bus.arb_error_vector), exp_err);
      set_req(0, 1'b0, 1'b0, 32'h13, 32'd0);
      tick();
      check("mis_err_sticky", 32'(bus.arb_error_vector), exp_err);

      // ---- port 1 read 0x44, req dropped during WAIT ----
      set_req(1, 1'b1, 1'b0, 32'h44, 32'd0);
      m_last = 1;
      for (int k = 1; k <= L + 2; k++) begin
         tick();
         check("drop_ack1", 32'(bus.m1_ack), 32'(k == L + 2));
         if (k == 2) set_req(1, 1'b0, 1'b0, 32'h44, 32'd0);
      end
      exp_err = exp_err | 32'h1;
      exp_rd[1] = ref_mem[17];
      check("drop_rdata", bus.m1_rdata, exp_rd[1]);
      check("drop_err", 32'(bus.arb_error_vector), exp_err);
      tick();
      check("drop_err_sticky", 32'(bus.arb_error_vector), exp_err);

      // ---- reset during WAIT of a port 0 read; port 1 pending ----
      set_req(0, 1'b1, 1'b0, 32'h20, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      cur_addr[0] = 32'h20;
      cur_addr[1] = 32'h24;
      set_req(1, 1'b1, 1'b0, 32'h24, 32'd0);
      #1;
      check_reset("async");
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_err   = '0;
      m_last    = 0;
      tick();
      check("rst_no_ack0", 32'(bus.m0_ack), 32'd0);
      check("rst_no_ack1", 32'(bus.m1_ack), 32'd0);
      rst = 1'b0;

      // ---- both ports hold reads: strict alternation from port 1 ----
      n = 0;
      for (int txn = 0; txn < 4; txn++) begin
         winner = (m_last == 0) ? 1 : 0;
         m_last = winner;
         seen = 1'b0;
         while (!seen && n < 12) begin
            tick();
            n++;
            seen = bus.m0_ack | bus.m1_ack;
         end
         check("rr_ack_seen", 32'(seen), 32'd1);
         check("rr_port", 32'(bus.m1_ack), 32'(winner));
         check("rr_other", 32'(bus.m0_ack), 32'(winner == 0));
         check("rr_latency", 32'(n), (txn == 0) ? 32'(L + 2) : 32'(L + 3));
         exp_rd[winner] = ref_mem[cur_addr[winner][7:2]];
         check("rr_rdata", (winner == 1) ? bus.m1_rdata : bus.m0_rdata, exp_rd[winner]);
         if (txn == 3) begin
            set_req(0, 1'b0, 1'b0, cur_addr[0], 32'd0);
            set_req(1, 1'b0, 1'b0, cur_addr[1], 32'd0);
         end else begin
            cur_addr[winner] = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            set_req(winner, 1'b1, 1'b0, cur_addr[winner], 32'd0);
         end
         tick();
         check("rr_ack_width0", 32'(bus.m0_ack), 32'd0);
         check("rr_ack_width1", 32'(bus.m1_ack), 32'd0);
         n = 1;
      end

      // ---- randomized traffic against the transaction-level model ----
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      next_arb = 0;
      exp_ack  = -1;
      grant_c  = -1;
      exp_port = 0;
      exp_we   = 1'b0;
      exp_val  = '0;
      for (int c = 0; c < N_RAND; c++) begin
         if (c == exp_ack && !exp_we) exp_rd[exp_port] = exp_val;
         check("rnd_ack0", 32'(bus.m0_ack), 32'(c == exp_ack && exp_port == 0));
         check("rnd_ack1", 32'(bus.m1_ack), 32'(c == exp_ack && exp_port == 1));
         check("rnd_busy", 32'(bus.arb_busy), 32'(grant_c >= 0 && c > grant_c && c <= exp_ack));
         check("rnd_rdata0", bus.m0_rdata, exp_rd[0]);
         check("rnd_rdata1", bus.m1_rdata, exp_rd[1]);

         if (c == exp_ack) begin
            pend[exp_port] = 1'b0;
            set_req(exp_port, 1'b0, r_we[exp_port], r_addr[exp_port], r_wdata[exp_port]);
         end

         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 2) == 0) begin
               pend[p]    = 1'b1;
               r_we[p]    = 1'($urandom_range(0, 1));
               r_addr[p]  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
               if ($urandom_range(0, 3) == 0) r_addr[p] = r_addr[p] | 32'($urandom_range(1, 3));
               r_wdata[p] = $urandom;
               set_req(p, 1'b1, r_we[p], r_addr[p], r_wdata[p]);
            end
         end

         if (c >= next_arb && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) winner = (m_last == 0) ? 1 : 0;
            else                    winner = pend[1] ? 1 : 0;
            m_last   = winner;
            grant_c  = c;
            exp_port = winner;
            exp_we   = r_we[winner];
            if (exp_we) ref_mem[r_addr[winner][7:2]] = r_wdata[winner];
            else        exp_val = ref_mem[r_addr[winner][7:2]];
            if (r_addr[winner][1:0] != 2'b00) exp_err = exp_err | 32'h2;
            exp_ack  = c + (exp_we ? 2 : L + 2);
            next_arb = exp_ack + 1;
         end
         tick();
      end
      check("rnd_err", 32'(bus.arb_error_vector), exp_err);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
